mmio_console_mon: RTL

Memory-mapped console and halt monitor. It snoops the CPU data-write bus alongside the data RAM and captures writes to a console address into a FIFO. The FIFO drains through a valid/ready byte-stream port to a UART or a simulation printer. A write to the halt address drains the FIFO, latches an exit code and raises a halt flag. The block also keeps retired-instruction and cycle counters.

---
 rtl/mmio_console_mon_pkg.sv | 15 +
 rtl/mmio_console_mon_sync_fifo.sv | 52 +++++
 rtl/mmio_console_mon.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mmio_console_mon_pkg.sv
// Shared definitions for the memory-mapped console and halt monitor:
// FSM state encoding and the default console/halt addresses, so the
// system top and the benches agree on them.
package mmio_console_mon_pkg;

    typedef enum logic [1:0] {
        MON_RUN    = 2'd0,
        MON_DRAIN  = 2'd1,
        MON_HALTED = 2'd2
    } mon_state_t;

    localparam logic [23:0] DEF_CON_ADDR  = 24'hFFFFFE;
    localparam logic [23:0] DEF_HALT_ADDR = 24'hFFFFFF;

endpackage

// File: rtl/mmio_console_mon_sync_fifo.sv
// mon_sync_fifo: single-clock FIFO with an extra pointer bit to tell full
// from empty. The head word is driven combinationally from storage and
// forced to zero while empty, so the output is clean out of reset.
module mon_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointer update; wrap modulo DEPTH falls out of the power-of-two width.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage write.
    // NOTE: the storage array has no reset; its contents are only visible
    // through the empty-gated head, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_console_mon.sv
// mmio_console_mon: snoops CPU data writes, queues console words into a
// FIFO drained through a valid/ready port, and handles the halt write
// (drain, latch exit code, raise halt). Also counts retired instructions
// and, when MON_CYCLE_COUNT_EN is defined, enabled cycles; otherwise the
// cycle count output is tied to zero.
module mmio_console_mon
    import mmio_console_mon_pkg::*;
#(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] CON_ADDR   = DEF_CON_ADDR,
    parameter logic [ADDR_W-1:0] HALT_ADDR  = DEF_HALT_ADDR,
    parameter int                FIFO_DEPTH = 16,
    parameter int                CNT_W      = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rstb,
    input  logic                          i_clk_en,
    input  logic [ADDR_W-1:0]             i_daddr,
    input  logic [DATA_W-1:0]             i_dwdata,
    input  logic                          i_dwr,
    input  logic                          i_instr_valid,
    output logic                          o_tx_valid,
    output logic [DATA_W-1:0]             o_tx_data,
    input  logic                          i_tx_ready,
    output logic                          o_halt,
    output logic [DATA_W-1:0]             o_exit_code,
    output logic [CNT_W-1:0]              o_instr_count,
    output logic [CNT_W-1:0]              o_cycle_count,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    mon_state_t       state;
    logic             in_run;
    logic             con_hit;
    logic             halt_hit;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    // Address decode and FIFO handshake qualification.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        in_run   = 1'b0;
        con_hit  = 1'b0;
        halt_hit = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        drop     = 1'b0;
        in_run   = (state == MON_RUN);
        con_hit  = i_clk_en && in_run && i_dwr && (i_daddr == CON_ADDR);
        halt_hit = i_clk_en && in_run && i_dwr && (i_daddr == HALT_ADDR);
        pop      = i_clk_en && !fifo_empty && i_tx_ready;
        // A full FIFO still accepts a push when the head leaves this cycle.
        push     = con_hit && (!fifo_full || pop);
        drop     = con_hit && fifo_full && !pop;
    end

    mon_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstb),
        .push  (push),
        .wdata (i_dwdata),
        .pop   (pop),
        .rdata (o_tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign o_tx_valid   = !fifo_empty;
    assign o_fifo_level = fifo_level;

    // Run/drain/halt sequencing with registered halt flag and exit code.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state       <= MON_RUN;
            o_halt      <= 1'b0;
            o_exit_code <= '0;
        end else if (i_clk_en) begin
            case (state)
                MON_RUN: begin
                    if (halt_hit) begin
                        o_exit_code <= i_dwdata;
                        state       <= MON_DRAIN;
                    end
                end
                MON_DRAIN: begin
                    // Level is checked before this cycle's pop, so the last
                    // pop is followed by one more cycle before halting.
                    if (fifo_level == '0) begin
                        state  <= MON_HALTED;
                        o_halt <= 1'b1;
                    end
                end
                default: begin
                    state  <= MON_HALTED;
                    o_halt <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flag for console words lost to a full FIFO.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb)   o_overflow <= 1'b0;
        else if (drop) o_overflow <= 1'b1;
    end

    // Retired-instruction counter; only runs before the halt write lands.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb)
            o_instr_count <= '0;
        else if (i_clk_en && in_run && i_instr_valid)
            o_instr_count <= o_instr_count + CNT_W'(1);
    end

`ifdef MON_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_q;

    // Enabled-cycle counter; stops once halted.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb)
            cycle_q <= '0;
        else if (i_clk_en && (state != MON_HALTED))
            cycle_q <= cycle_q + CNT_W'(1);
    end

    assign o_cycle_count = cycle_q;
`else
    assign o_cycle_count = '0;
`endif

endmodule
